// File: rtl/perf_counter_bank.sv
// perf_counter_bank: cycle counter plus NUM_CH event counters with auto-halt and a registered read port.
// Build option PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module perf_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              CLEAR,
    input  logic [NUM_CH-1:0] EVENT,
    input  logic [CNT_W-1:0]  CYCLE_LIMIT,
    input  logic              RD_REQ,
    input  logic [SEL_W-1:0]  RD_SEL,
    output logic              RD_ACK,
    output logic [CNT_W-1:0]  RD_DATA,
    output logic [CNT_W-1:0]  CYCLES,
    output logic [1:0]        STATE,
    output logic              HALT,
    output logic [NUM_CH-1:0] OVF
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cyc_q;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;

    logic              vld_p1;
    logic [CNT_W-1:0]  rd_data_p1;

    logic [CNT_W-1:0]  rd_mux_p0;
    logic [CNT_W-1:0]  cyc_nxt;
    logic              cyc_wrap;
    logic [CNT_W-1:0]  ch_nxt [NUM_CH];
    logic [NUM_CH-1:0] ch_wrap;
    logic              halt_hit;

    // Returns {attempted increment past all-ones, next value}.
    function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
`ifdef PERF_SATURATE_EN
            cnt_inc = {1'b1, CNT_MAX};
`else
            cnt_inc = {1'b1, {CNT_W{1'b0}}};
`endif
        end else begin
            cnt_inc = {1'b0, v + CNT_W'(1)};
        end
    endfunction

    always_comb begin
        {cyc_wrap, cyc_nxt} = cnt_inc(cyc_q);
        for (int i = 0; i < NUM_CH; i++) begin
            {ch_wrap[i], ch_nxt[i]} = cnt_inc(cnt_q[i]);
        end
    end

    // An increment from all-ones never lands on a nonzero limit when wrapping, and a
    // saturated cycle counter is not really advancing, so it must not re-trigger halt.
    assign halt_hit = (CYCLE_LIMIT != '0) && (cyc_nxt == CYCLE_LIMIT) && !cyc_wrap;

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_mux_p0 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(RD_SEL) == i) rd_mux_p0 = cnt_q[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            ovf_q      <= '0;
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            // read stage p0 -> p1: samples counts before this edge's update
            vld_p1 <= RD_REQ;
            if (RD_REQ) rd_data_p1 <= rd_mux_p0;

            if (CLEAR) begin
                state_q <= ST_IDLE;
                cyc_q   <= '0;
                ovf_q   <= '0;
                for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (START && !STOP) state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (STOP) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cyc_q <= cyc_nxt;
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (EVENT[i]) begin
                                    cnt_q[i] <= ch_nxt[i];
                                    if (ch_wrap[i]) ovf_q[i] <= 1'b1;
                                end
                            end
                            if (halt_hit) state_q <= ST_HALTED;
                        end
                    end
                    ST_HALTED: begin
                        state_q <= ST_HALTED;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign RD_ACK  = vld_p1;
    assign RD_DATA = rd_data_p1;
    assign CYCLES  = cyc_q;
    assign STATE   = state_q;
    assign HALT    = state_q[1];
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: vector table, hand sequences and randomized run against a reference model.
`timescale 1ns/1ps
module tb_perf_counter_bank;

    localparam int NCH  = 4;
    localparam int CW   = 32;
    localparam int SW   = 2;
    localparam int SNCH = 3;
    localparam int SCW  = 4;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;
`ifdef PERF_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start, stop, clear, rd_req;
    logic [NCH-1:0] ev;
    logic [CW-1:0]  lim;
    logic [SW-1:0]  rd_sel;
    logic           rd_ack, halt;
    logic [CW-1:0]  rd_data, cycles;
    logic [1:0]     state;
    logic [NCH-1:0] ovf;

    logic            s_rst_n, s_start, s_stop, s_clear, s_rd_req;
    logic [SNCH-1:0] s_ev;
    logic [SCW-1:0]  s_lim;
    logic [SW-1:0]   s_rd_sel;
    logic            s_rd_ack, s_halt;
    logic [SCW-1:0]  s_rd_data, s_cycles;
    logic [1:0]      s_state;
    logic [SNCH-1:0] s_ovf;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .STOP(stop), .CLEAR(clear),
        .EVENT(ev), .CYCLE_LIMIT(lim), .RD_REQ(rd_req), .RD_SEL(rd_sel),
        .RD_ACK(rd_ack), .RD_DATA(rd_data), .CYCLES(cycles), .STATE(state),
        .HALT(halt), .OVF(ovf)
    );

    perf_counter_bank #(.NUM_CH(SNCH), .CNT_W(SCW), .SEL_W(SW)) dut_s (
        .CLK(clk), .RST_N(s_rst_n), .START(s_start), .STOP(s_stop), .CLEAR(s_clear),
        .EVENT(s_ev), .CYCLE_LIMIT(s_lim), .RD_REQ(s_rd_req), .RD_SEL(s_rd_sel),
        .RD_ACK(s_rd_ack), .RD_DATA(s_rd_data), .CYCLES(s_cycles), .STATE(s_state),
        .HALT(s_halt), .OVF(s_ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // reference model of the main instance
    int             m_st;
    longint         m_cyc;
    longint         m_cnt [NCH];
    bit [NCH-1:0]   m_ovf;
    bit             m_ack;
    longint         m_data;

    typedef struct {
        logic       start;
        logic       stop;
        logic       clear;
        logic [3:0] ev;
        logic       rd_req;
        logic [1:0] rd_sel;
        logic [1:0] exp_state;
        int         exp_cyc;
        logic       exp_ack;
        int         exp_data;
    } vec_t;
    vec_t tv [14];

    function automatic vec_t mkv(input logic st, input logic sp, input logic cl,
                                 input logic [3:0] e, input logic rq, input logic [1:0] sel,
                                 input logic [1:0] es, input int ec, input logic ea, input int ed);
        vec_t v;
        v.start = st; v.stop = sp; v.clear = cl; v.ev = e; v.rd_req = rq; v.rd_sel = sel;
        v.exp_state = es; v.exp_cyc = ec; v.exp_ack = ea; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_st = 0; m_cyc = 0; m_ovf = '0; m_ack = 1'b0; m_data = 0;
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        end else begin
            m_ack = rd_req;
            if (rd_req) m_data = m_cnt[rd_sel];
            if (clear) begin
                m_st = 0; m_cyc = 0; m_ovf = '0;
                for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            end else if (m_st == 1) begin
                if (stop) begin
                    m_st = 0;
                end else begin
                    m_cyc = (m_cyc + 1) % (MAXV + 1);
                    for (int i = 0; i < NCH; i++) begin
                        if (ev[i]) begin
                            if (m_cnt[i] == MAXV) begin
                                m_ovf[i] = 1'b1;
                                m_cnt[i] = SAT ? MAXV : 0;
                            end else begin
                                m_cnt[i] = m_cnt[i] + 1;
                            end
                        end
                    end
                    if (lim != 0 && m_cyc == longint'(lim)) m_st = 2;
                end
            end else if (m_st == 0 && start && !stop) begin
                m_st = 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"},  64'(state),   64'(m_st));
        chk({tag, "_halt"},   64'(halt),    (m_st == 2) ? 64'd1 : 64'd0);
        chk({tag, "_cycles"}, 64'(cycles),  m_cyc);
        chk({tag, "_ovf"},    64'(ovf),     64'(m_ovf));
        chk({tag, "_ack"},    64'(rd_ack),  64'(m_ack));
        chk({tag, "_data"},   64'(rd_data), m_data);
    endtask

    initial begin
        tv[0]  = mkv(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 2'd1, 0, 1'b0, 0);
        tv[1]  = mkv(1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 2'd0, 2'd1, 1, 1'b0, 0);
        tv[2]  = mkv(1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 2'd1, 2, 1'b0, 0);
        tv[3]  = mkv(1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 2'd0, 2'd1, 3, 1'b0, 0);
        tv[4]  = mkv(1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd1, 2'd1, 4, 1'b1, 2);
        tv[5]  = mkv(1'b0, 1'b0, 1'b0, 4'h3, 1'b1, 2'd1, 2'd1, 5, 1'b1, 2);
        tv[6]  = mkv(1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd1, 2'd1, 6, 1'b1, 3);
        tv[7]  = mkv(1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 2'd0, 2'd1, 7, 1'b0, 3);
        tv[8]  = mkv(1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 2'd1, 8, 1'b0, 3);
        tv[9]  = mkv(1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 2'd0, 2'd0, 8, 1'b1, 8);
        tv[10] = mkv(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 2'd0, 8, 1'b1, 4);
        tv[11] = mkv(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 2'd0, 8, 1'b1, 8);
        tv[12] = mkv(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 2'd0, 8, 1'b1, 0);
        tv[13] = mkv(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 8, 1'b0, 0);

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        ev = '0; lim = '0; rd_req = 1'b0; rd_sel = '0;
        s_rst_n = 1'b0; s_start = 1'b0; s_stop = 1'b0; s_clear = 1'b0;
        s_ev = '0; s_lim = '0; s_rd_req = 1'b0; s_rd_sel = '0;

        // reset, then events with no START
        tick(); tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_ack", 64'(rd_ack), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1; ev = 4'hF;
        repeat (5) tick();
        chk("idle_state", 64'(state), 64'd0);
        chk("idle_cycles", 64'(cycles), 64'd0);
        chk("idle_ovf", 64'(ovf), 64'd0);
        ev = '0;
        for (int s = 0; s < NCH; s++) begin
            rd_req = 1'b1; rd_sel = SW'(s);
            tick();
            chk($sformatf("idle_rd%0d_ack", s), 64'(rd_ack), 64'd1);
            chk($sformatf("idle_rd%0d_data", s), 64'(rd_data), 64'd0);
        end
        rd_req = 1'b0;
        tick();

        // basic count and back-to-back reads from the vector table
        for (int r = 0; r < 14; r++) begin
            start = tv[r].start; stop = tv[r].stop; clear = tv[r].clear;
            ev = tv[r].ev; rd_req = tv[r].rd_req; rd_sel = tv[r].rd_sel;
            tick();
            chk($sformatf("tv%0d_state", r), 64'(state), 64'(tv[r].exp_state));
            chk($sformatf("tv%0d_cycles", r), 64'(cycles), 64'(tv[r].exp_cyc));
            chk($sformatf("tv%0d_ack", r), 64'(rd_ack), 64'(tv[r].exp_ack));
            chk($sformatf("tv%0d_data", r), 64'(rd_data), 64'(tv[r].exp_data));
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0; ev = '0; rd_req = 1'b0; rd_sel = '0;

        // halt on cycle budget
        clear = 1'b1; tick(); clear = 1'b0;
        lim = 32'd5; ev = 4'b0100; start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("halt_cyc%0d", k), 64'(cycles), 64'(k));
            chk($sformatf("halt_flag%0d", k), 64'(halt), (k == 5) ? 64'd1 : 64'd0);
        end
        chk("halt_state", 64'(state), 64'd2);
        start = 1'b1; repeat (3) tick(); start = 1'b0;
        chk("halt_hold_state", 64'(state), 64'd2);
        chk("halt_hold_cycles", 64'(cycles), 64'd5);
        rd_req = 1'b1; rd_sel = 2'd2; tick();
        chk("halt_rd_ch2", 64'(rd_data), 64'd5);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_rd_preclear", 64'(rd_data), 64'd5);
        chk("clr_state", 64'(state), 64'd0);
        chk("clr_halt", 64'(halt), 64'd0);
        chk("clr_cycles", 64'(cycles), 64'd0);
        tick();
        chk("clr_rd_ch2", 64'(rd_data), 64'd0);
        rd_req = 1'b0; lim = '0; ev = '0;

        // priority: CLEAR beats STOP and START; reset drops a pending read
        start = 1'b1; tick(); start = 1'b0; ev = 4'hF;
        repeat (3) tick();
        chk("prio_run_cycles", 64'(cycles), 64'd3);
        clear = 1'b1; stop = 1'b1; start = 1'b1; tick();
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        chk("prio_state", 64'(state), 64'd0);
        chk("prio_cycles", 64'(cycles), 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        rd_req = 1'b1; rd_sel = 2'd0; tick();
        chk("prerst_rd", 64'(rd_data), 64'd4);
        rst_n = 1'b0; tick(); rst_n = 1'b1; rd_req = 1'b0; ev = '0;
        chk("midrst_ack", 64'(rd_ack), 64'd0);
        chk("midrst_data", 64'(rd_data), 64'd0);
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_cycles", 64'(cycles), 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);

        // narrow instance: overflow and out-of-range select
        s_rst_n = 1'b1; s_start = 1'b1; tick(); s_start = 1'b0; s_ev = 3'b100;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 15) chk("s_ovf_before", 64'(s_ovf), 64'd0);
            if (k == 16) chk("s_ovf_set", 64'(s_ovf), 64'd4);
        end
        s_ev = '0; s_stop = 1'b1; tick(); s_stop = 1'b0;
        chk("s_state_stop", 64'(s_state), 64'd0);
        chk("s_halt", 64'(s_halt), 64'd0);
        chk("s_cycles", 64'(s_cycles), SAT ? 64'd15 : 64'd1);
        s_rd_req = 1'b1; s_rd_sel = 2'd2; tick();
        chk("s_rd_ch2", 64'(s_rd_data), SAT ? 64'd15 : 64'd1);
        chk("s_rd_ch2_ack", 64'(s_rd_ack), 64'd1);
        chk("s_ovf_sticky", 64'(s_ovf), 64'd4);
        s_rd_sel = 2'd3; tick();
        chk("s_rd_oob", 64'(s_rd_data), 64'd0);
        chk("s_rd_oob_ack", 64'(s_rd_ack), 64'd1);
        s_rd_req = 1'b0; tick();
        chk("s_ack_low", 64'(s_rd_ack), 64'd0);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0)
                lim = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
            rst_n  = ($urandom_range(0, 199) != 0);
            clear  = ($urandom_range(0, 39) == 0);
            stop   = ($urandom_range(0, 9) == 0);
            start  = ($urandom_range(0, 3) == 0);
            ev     = 4'($urandom);
            rd_req = ($urandom_range(0, 1) != 0);
            rd_sel = 2'($urandom);
            tick();
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised performance/instruction counter bank for the single-cycle processor. It counts clock cycles and up to NUM_CH event strobes (instructions retired, memory writes, branches taken, ...) and halts automatically after a programmable cycle budget. A registered read port with a request/acknowledge handshake returns any channel's count. It sits beside the processor core, driven by the core's control strobes, and gives benches and debug logic synthesisable counts instead of testbench-side `$display` tallies.

## Interface
Parameters:
- NUM_CH, 4: number of event channels (1..16).
- CNT_W, 32: width of every counter, including the cycle counter.
- SEL_W, 2: width of RD_SEL; must satisfy 2^SEL_W >= NUM_CH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  begin/resume counting.
- STOP  in  1  pause counting.
- CLEAR  in  1  zero all counters and OVF, return to IDLE.
- EVENT  in  NUM_CH  per-channel increment strobes.
- CYCLE_LIMIT  in  CNT_W  cycle budget; 0 = unlimited.
- RD_REQ  in  1  read request, one per cycle max.
- RD_SEL  in  SEL_W  channel index for the read.
- RD_ACK  out  1  one-cycle read-valid pulse.
- RD_DATA  out  CNT_W  read result.
- CYCLES  out  CNT_W  live cycle count.
- STATE  out  2  00 IDLE, 01 RUN, 10 HALTED.
- HALT  out  1  high while in HALTED.
- OVF  out  NUM_CH  sticky per-channel overflow flags.

## Operation
- FSM states: IDLE, RUN, HALTED. STATE 11 is never produced.
- Input priority at each edge: RST_N low > CLEAR > STOP > START.
- IDLE: counters hold. START with STOP low moves to RUN. START with STOP high stays in IDLE.
- RUN, at each edge with STOP and CLEAR low:
  - CYCLES increments by 1.
  - Channel i increments by 1 when EVENT[i] is high.
- RUN with STOP high: move to IDLE; no increment at that edge.
- Halt condition: CYCLE_LIMIT != 0 and the incremented CYCLES equals CYCLE_LIMIT. Move to HALTED at that same edge; that edge's events are still counted.
- CYCLE_LIMIT is sampled each edge. If the limit is lowered below the current CYCLES, no halt occurs until CYCLES wraps back to it.
- HALTED: counters frozen; START and STOP ignored; only CLEAR or reset exits, both to IDLE.
- CLEAR, in any state: all counters and OVF go to 0, state goes to IDLE.
- Overflow: a channel at all-ones that is incremented wraps to 0 and sets its OVF bit. OVF clears only on CLEAR or reset. The cycle counter wraps silently.
- Events in IDLE or HALTED are ignored.
- Read port:
  - RD_REQ sampled high at edge k captures the value of channel RD_SEL as it stood before edge k's increment.
  - RD_DATA is valid and RD_ACK=1 during the cycle after edge k.
  - RD_SEL >= NUM_CH returns 0, still acknowledged.
  - Reads are allowed in every state, including the same edge as CLEAR (pre-clear value returned).
  - Back-to-back requests give back-to-back acks.
  - RD_DATA holds its last value when RD_ACK is low.

## Timing
- Reset (RST_N low at an edge): STATE=IDLE, HALT=0, CYCLES=0, all channel counts 0, OVF=0, RD_ACK=0, RD_DATA=0. A read in flight is dropped.
- START sampled at edge k: STATE=RUN after edge k; the first counted edge is k+1.
- After N counted edges, CYCLES=N.
- HALT and STATE=HALTED are visible in the cycle after the halting edge.
- Read latency: exactly 1 cycle from RD_REQ to RD_ACK.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- PERF_SATURATE_EN defined: channel counters saturate at all-ones instead of wrapping. OVF still sets on the first attempted increment past all-ones. The cycle counter also saturates, and a saturated cycle counter with nonzero CYCLE_LIMIT does not re-trigger halt.
- PERF_SATURATE_EN undefined: wrap-around behaviour as in Operation.

## Test plan
- Reset and idle: RST_N low 2 cycles, then EVENT=4'hF for 5 cycles with no START -> all counts 0, STATE=00, OVF=0.
- Basic count: START at edge 0, EVENT[0]=1 every cycle, EVENT[1]=1 on alternate cycles, STOP at edge 9 -> CYCLES=8, ch0=8, ch1=4, STATE=00.
- Halt: CYCLE_LIMIT=5, START, EVENT[2]=1 constantly -> HALT=1 after edge 5, CYCLES=5, ch2=5; further START ignored; CLEAR -> all 0, STATE=00.
- Overflow with CNT_W=4: 17 events on ch3 -> ch3=1, OVF[3]=1 (with PERF_SATURATE_EN: ch3=15, OVF[3]=1).
- Read port: RD_REQ with RD_SEL=1 on 3 consecutive cycles while counting -> 3 consecutive RD_ACK pulses returning pre-increment values; RD_SEL=3 with NUM_CH=3 -> RD_DATA=0, RD_ACK=1.
- Priority: CLEAR, STOP and START all high in RUN -> counters 0, STATE=00; RST_N low mid-RUN with RD_REQ pending -> no RD_ACK, all outputs at reset values.
